spi_cmd_sequencer: RTL and testbench
====================================

Name: spi_cmd_sequencer

Overview:
- Scheduler between the UART receive FIFO and the SPI word driver.
- Pulls 4-byte big-endian commands {period[15:0], value[15:0]} from the FIFO and double-buffers one decoded command.
- Issues each value to the SPI driver at a pace set by the previous command's period, and generates chip-select.
- Replaces the ad-hoc command/timer logic in the top level with one verifiable unit.

Parameters:
- VAL_SHIFT, 2: right-shift applied to value before transmission; zeros fill the MSBs.
- TW, 16: width of the period timer and of value.

Ports:
- clk  in  1  system clock (40 MHz PLL output)
- resetn  in  1  asynchronous active-low reset
- fifo_empty  in  1  receive FIFO empty flag
- fifo_data  in  8  FIFO read data; valid the cycle after fifo_rd
- fifo_rd  out  1  FIFO read strobe, one byte per cycle asserted
- spi_running  in  1  SPI driver busy
- spi_we  out  1  single-cycle start pulse to the SPI driver
- spi_tx  out  16  word to send: {VAL_SHIFT zeros, value[15:VAL_SHIFT]}; held stable from spi_we until the next issue
- csn  out  1  SPI chip select, active low, registered
- busy  out  1  high while a command is pending, issuing or being timed
- cmd_cnt  out  16  count of issued commands; wraps

Behaviour:
- Reset (async, resetn=0):
  - fifo_rd=0, spi_we=0, spi_tx=0, csn=1, busy=0, cmd_cnt=0, timer=0.
  - Both FSMs go to IDLE; the pending slot is emptied and the byte counter is cleared.
- Reset mid-command: a partially assembled command is discarded. Reset mid-SPI-word: csn rises asynchronously and the driver is left to finish on its own.
- Fetch FSM states: F_IDLE, F_READ, F_SHIFT, F_HOLD.
  - F_IDLE:
    - If !fifo_empty: assert fifo_rd for one cycle and go to F_READ.
  - F_READ:
    - Shift in the byte: asm <= {asm[23:0], fifo_data}; byte counter +1.
    - Byte counter <3 and !fifo_empty: assert fifo_rd again and stay.
    - Byte counter <3 and fifo_empty: go to F_IDLE, keeping the partial command and the counter.
    - 4th byte: go to F_SHIFT.
  - F_SHIFT:
    - Pending slot empty: copy asm to pending (period=asm[31:16], value=asm[15:0]), set pending_valid, clear the byte counter, go to F_IDLE.
    - Slot full: go to F_HOLD.
  - F_HOLD:
    - No FIFO reads (backpressure).
    - Transfer to pending in the first cycle the slot is empty, including the cycle the issue FSM clears it; then go to F_IDLE.
  - Sustained throughput: 1 byte per cycle while the FIFO is non-empty.
- Issue FSM states: I_IDLE, I_WAIT, I_FIRE.
  - I_IDLE → I_WAIT when pending_valid.
  - I_WAIT → I_FIRE when timer==0 && !spi_running.
  - I_FIRE:
    - Exactly one cycle.
    - spi_we=1 with spi_tx driven from the pending value in the same cycle.
    - timer <= pending period; pending_valid cleared; cmd_cnt +1.
    - Next state: I_WAIT if another pending command is valid next cycle, else I_IDLE.
- Timer:
  - Decrements by 1 per cycle and saturates at 0.
  - Loading in I_FIRE overrides the decrement.
  - A period of N gives N clk cycles after the spi_we cycle before the next spi_we; the next word also waits for !spi_running.
  - Period 0: the next command fires as soon as spi_running is low and the command is pending.
- csn: registered, csn <= !(spi_we | spi_running). It falls one cycle after spi_we and rises one cycle after spi_running falls.
- busy = pending_valid | (issue state != I_IDLE) | (timer != 0).
- Simultaneous events:
  - F_SHIFT transfer and I_FIRE clear in the same cycle: the new command is accepted and the old one fires; no loss.
  - FIFO data is never read while in F_HOLD.
- Width rules: cmd_cnt wraps 0xFFFF→0; spi_tx shift is logical.

Decomposition:
- Package ess_pkg holds:
  - the fetch and issue state enums;
  - CMD_BYTES=4;
  - a command struct {period, value}.
- Sub-module seq_timer: loadable, saturating down-counter with a done flag (~30 lines). Everything else stays inline.

Test Plan:
- Single command: bytes 00 0A 12 34 → one spi_we with spi_tx=0x048D; csn low during spi_running; cmd_cnt=1; timer loaded with 10.
- Pacing: two commands, period 100 then 0 → second spi_we exactly 100 cycles after the first (driver idle); busy falls after the second word completes.
- Backpressure: 12 bytes preloaded, SPI held running → fifo_rd stops after 8 bytes (one pending + one held); the remaining 4 are read only after the first fire; all 3 values issued in order.
- Byte gaps: 1 cycle of fifo_empty between each byte → correct assembly of AB CD 00 04 gives spi_tx=0x0001.
- Period 0 back-to-back: 3 commands with period 0 → each spi_we is gated only by spi_running falling; no spi_we while spi_running=1.
- Reset in F_READ after 2 bytes, then bytes 00 01 FF FC → spi_tx=0x3FFF; csn=1 and all outputs at reset values during resetn=0.

Source files
------------

// File: rtl/ess_pkg.sv
// rtl/ess_pkg.sv - shared types for the SPI command sequencer
package ess_pkg;

  localparam int CMD_BYTES = 4;

  typedef enum logic [1:0] {
    F_IDLE,
    F_READ,
    F_SHIFT,
    F_HOLD
  } fetch_state_t;

  typedef enum logic [1:0] {
    I_IDLE,
    I_WAIT,
    I_FIRE
  } issue_state_t;

  typedef struct packed {
    logic [15:0] period;
    logic [15:0] value;
  } cmd_t;

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// rtl/spi_cmd_sequencer_if.sv - FIFO-side and SPI-side signals of the command sequencer
interface spi_cmd_sequencer_if #(
  parameter int TW = 16
);
  logic          fifo_empty;
  logic [7:0]    fifo_data;
  logic          fifo_rd;
  logic          spi_running;
  logic          spi_we;
  logic [TW-1:0] spi_tx;
  logic          csn;
  logic          busy;
  logic [15:0]   cmd_cnt;

  modport slave (
    input  fifo_empty, fifo_data, spi_running,
    output fifo_rd, spi_we, spi_tx, csn, busy, cmd_cnt
  );

  modport master (
    output fifo_empty, fifo_data, spi_running,
    input  fifo_rd, spi_we, spi_tx, csn, busy, cmd_cnt
  );
endinterface

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - loadable saturating down-counter pacing consecutive SPI issues
module seq_timer #(
  parameter int TW   = 16,
  parameter int LEAD = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] count,
  output logic          done
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Released LEAD counts early: the issue FSM spends one cycle deciding and one
  // registering spi_we, so a period of N spaces the start pulses exactly N cycles.
  assign done = (count <= TW'(LEAD));

endmodule

// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - fetches 4-byte commands from the UART FIFO and issues paced SPI words
module spi_cmd_sequencer
  import ess_pkg::*;
#(
  parameter int VAL_SHIFT = 2,
  parameter int TW        = 16
) (
  input  logic               clk,
  input  logic               resetn,
  spi_cmd_sequencer_if.slave bus
);

  localparam logic [1:0] LAST_BYTE = 2'(CMD_BYTES - 1);

  fetch_state_t           f_state;
  issue_state_t           i_state;
  logic [8*CMD_BYTES-1:0] asm_q;
  logic [1:0]             byte_cnt;
  cmd_t                   pend;
  logic                   pend_valid;
  logic                   run_q;
  logic                   rd;
  logic                   fire;
  logic                   slot_free;
  logic                   load_pend;
  logic                   spi_we_q;
  logic [TW-1:0]          spi_tx_q;
  logic                   csn_q;
  logic [15:0]            cmd_cnt_q;
  logic [TW-1:0]          timer;
  logic                   timer_done;

  assign fire      = (i_state == I_FIRE);
  assign slot_free = !pend_valid || fire;
  assign load_pend = ((f_state == F_SHIFT) || (f_state == F_HOLD)) && slot_free;

  // Read strobe decodes fifo_empty directly so the last byte is never over-read at full rate.
  assign rd = run_q && !bus.fifo_empty &&
              ((f_state == F_IDLE) || ((f_state == F_READ) && (byte_cnt != LAST_BYTE)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      f_state    <= F_IDLE;
      asm_q      <= '0;
      byte_cnt   <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (load_pend) begin
        pend       <= cmd_t'(asm_q);
        pend_valid <= 1'b1;
      end else if (fire) begin
        pend_valid <= 1'b0;
      end
      case (f_state)
        F_IDLE: if (rd) f_state <= F_READ;
        F_READ: begin
          asm_q    <= {asm_q[8*CMD_BYTES-9:0], bus.fifo_data};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == LAST_BYTE) f_state <= F_SHIFT;
          else if (!rd)              f_state <= F_IDLE;
        end
        F_SHIFT, F_HOLD: begin
          if (slot_free) begin
            byte_cnt <= '0;
            f_state  <= F_IDLE;
          end else begin
            f_state <= F_HOLD;
          end
        end
        default: f_state <= F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_state   <= I_IDLE;
      spi_we_q  <= 1'b0;
      spi_tx_q  <= '0;
      csn_q     <= 1'b1;
      cmd_cnt_q <= '0;
    end else begin
      csn_q    <= !(spi_we_q || bus.spi_running);
      spi_we_q <= 1'b0;
      case (i_state)
        I_IDLE: if (pend_valid) i_state <= I_WAIT;
        I_WAIT: begin
          if (timer_done && !bus.spi_running) begin
            i_state  <= I_FIRE;
            spi_we_q <= 1'b1;
            spi_tx_q <= TW'(pend.value >> VAL_SHIFT);
          end
        end
        I_FIRE: begin
          cmd_cnt_q <= cmd_cnt_q + 16'd1;
          i_state   <= load_pend ? I_WAIT : I_IDLE;
        end
        default: i_state <= I_IDLE;
      endcase
    end
  end

  seq_timer #(.TW(TW), .LEAD(2)) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (fire),
    .load_val (TW'(pend.period)),
    .count    (timer),
    .done     (timer_done)
  );

  assign bus.fifo_rd = rd;
  assign bus.spi_we  = spi_we_q;
  assign bus.spi_tx  = spi_tx_q;
  assign bus.csn     = csn_q;
  assign bus.cmd_cnt = cmd_cnt_q;
  assign bus.busy    = pend_valid || (i_state != I_IDLE) || (timer != '0);

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - randomized self-checking bench with FIFO and SPI driver models
module tb_spi_cmd_sequencer;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  spi_cmd_sequencer_if #(.TW(16)) bus ();

  spi_cmd_sequencer #(.VAL_SHIFT(2), .TW(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0]  fifo_q[$];
  logic [15:0] exp_tx[$];
  int          exp_per[$];
  logic [15:0] obs_tx[$];
  int          obs_cyc[$];
  int          pop_cyc[$];
  int rd_count = 0;
  int overread = 0;
  int overlap = 0;
  int spi_len = 4;
  int spi_rem = 0;
  int exp_cnt = 0;
  bit gap = 1'b0;
  bit hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO: data appears the cycle after fifo_rd. SPI driver: busy spi_len cycles after spi_we.
  initial begin
    bit rd_c, we_c;
    bus.fifo_empty  = 1'b1;
    bus.fifo_data   = 8'h00;
    bus.spi_running = 1'b0;
    forever begin
      @(negedge clk);
      rd_c = bus.fifo_rd;
      we_c = bus.spi_we;
      if (we_c) begin
        obs_tx.push_back(bus.spi_tx);
        obs_cyc.push_back(cyc);
        if (bus.spi_running) overlap++;
      end
      @(posedge clk);
      #1;
      if (rd_c) begin
        if (fifo_q.size() > 0) begin
          bus.fifo_data = fifo_q.pop_front();
          rd_count++;
          pop_cyc.push_back(cyc);
        end else begin
          overread++;
        end
      end
      if (we_c) spi_rem = spi_len;
      else if (spi_rem > 0) spi_rem--;
      bus.spi_running = hold || (spi_rem > 0);
      bus.fifo_empty  = (fifo_q.size() == 0) || (gap && rd_c);
    end
  end

  task automatic push_cmd(input logic [15:0] p, input logic [15:0] v);
    fifo_q.push_back(p[15:8]);
    fifo_q.push_back(p[7:0]);
    fifo_q.push_back(v[15:8]);
    fifo_q.push_back(v[7:0]);
    exp_tx.push_back(v >> 2);
    exp_per.push_back(int'(p));
  endtask

  task automatic clear_obs();
    obs_tx.delete();
    obs_cyc.delete();
    exp_tx.delete();
    exp_per.delete();
    pop_cyc.delete();
    rd_count = 0;
    overlap  = 0;
    overread = 0;
  endtask

  task automatic wait_fires(input int n, input int budget, output bit ok);
    int k = 0;
    while (obs_tx.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    ok = (obs_tx.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int k = 0;
    while ((bus.busy || bus.spi_running) && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    ok = !bus.busy && !bus.spi_running;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    fifo_q.push_back(8'h55);
    repeat (3) @(negedge clk);
    #1;
    n_cmp += 6;
    if (bus.fifo_rd !== 1'b0) begin n_bad++; $display("FAIL reset_fifo_rd: got %b want 0", bus.fifo_rd); end
    if (bus.spi_we !== 1'b0) begin n_bad++; $display("FAIL reset_spi_we: got %b want 0", bus.spi_we); end
    if (bus.spi_tx !== 16'h0000) begin n_bad++; $display("FAIL reset_spi_tx: got %h want 0000", bus.spi_tx); end
    if (bus.csn !== 1'b1) begin n_bad++; $display("FAIL reset_csn: got %b want 1", bus.csn); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.cmd_cnt !== 16'h0000) begin n_bad++; $display("FAIL reset_cmd_cnt: got %h want 0000", bus.cmd_cnt); end
    fifo_q.delete();
    @(negedge clk);
    resetn  = 1'b1;
    exp_cnt = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    int bad_csn = 0;
    clear_obs();
    spi_len = 6;
    push_cmd(16'h000A, 16'h1234);
    wait_fires(1, 100, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL single_fire: got %0d pulses want 1", obs_tx.size());
      return;
    end
    exp_cnt += 1;
    n_cmp++;
    if (obs_tx[0] !== 16'h048D) begin n_bad++; $display("FAIL single_tx: got %h want 048d", obs_tx[0]); end
    @(negedge clk);
    #1;
    n_cmp += 3;
    if (dut.timer !== 16'd10) begin n_bad++; $display("FAIL single_timer: got %0d want 10", dut.timer); end
    if (bus.cmd_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL single_cmd_cnt: got %0d want %0d", bus.cmd_cnt, exp_cnt); end
    if (bus.csn !== 1'b0) begin n_bad++; $display("FAIL single_csn_fall: got %b want 0", bus.csn); end
    for (int k = 2; k <= spi_len + 2; k++) begin
      @(negedge clk);
      #1;
      if (bus.csn !== ((k <= spi_len + 1) ? 1'b0 : 1'b1)) bad_csn++;
    end
    n_cmp++;
    if (bad_csn != 0) begin n_bad++; $display("FAIL single_csn_window: got %0d bad cycles want 0", bad_csn); end
    wait_idle(100, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL single_idle: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_pacing();
    bit ok;
    int k = 0;
    int low = 0;
    logic [15:0] v1, v2;
    clear_obs();
    spi_len = 8;
    v1 = 16'($urandom);
    v2 = 16'($urandom);
    push_cmd(16'd100, v1);
    push_cmd(16'd0, v2);
    wait_fires(1, 100, ok);
    while (ok && obs_tx.size() < 2 && k < 400) begin
      @(negedge clk);
      #1;
      if (obs_tx.size() < 2 && !bus.busy) low++;
      k++;
    end
    n_cmp++;
    if (obs_tx.size() < 2) begin
      n_bad++; $display("FAIL pacing_fires: got %0d pulses want 2", obs_tx.size());
      return;
    end
    exp_cnt += 2;
    n_cmp += 4;
    if (obs_tx[0] !== exp_tx[0]) begin n_bad++; $display("FAIL pacing_tx0: got %h want %h", obs_tx[0], exp_tx[0]); end
    if (obs_tx[1] !== exp_tx[1]) begin n_bad++; $display("FAIL pacing_tx1: got %h want %h", obs_tx[1], exp_tx[1]); end
    if (obs_cyc[1] - obs_cyc[0] != 100) begin n_bad++; $display("FAIL pacing_gap: got %0d want 100", obs_cyc[1] - obs_cyc[0]); end
    if (low != 0) begin n_bad++; $display("FAIL pacing_busy: got %0d low cycles want 0", low); end
    wait_idle(100, ok);
    n_cmp++;
    if (!ok || bus.cmd_cnt !== 16'(exp_cnt)) begin
      n_bad++; $display("FAIL pacing_end: got busy=%b cnt=%0d want 0/%0d", bus.busy, bus.cmd_cnt, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_obs();
    spi_len = 5;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) push_cmd(16'($urandom_range(0, 20)), 16'($urandom));
    repeat (40) @(negedge clk);
    #1;
    n_cmp += 2;
    if (rd_count != 8) begin n_bad++; $display("FAIL bp_reads_held: got %0d want 8", rd_count); end
    if (obs_tx.size() != 0) begin n_bad++; $display("FAIL bp_no_fire: got %0d want 0", obs_tx.size()); end
    hold = 1'b0;
    wait_fires(3, 500, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL bp_fires: got %0d pulses want 3", obs_tx.size());
      return;
    end
    exp_cnt += 3;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs_tx[i] !== exp_tx[i]) begin n_bad++; $display("FAIL bp_tx%0d: got %h want %h", i, obs_tx[i], exp_tx[i]); end
    end
    n_cmp += 2;
    if (rd_count != 12) begin n_bad++; $display("FAIL bp_reads_total: got %0d want 12", rd_count); end
    if (pop_cyc.size() < 9 || pop_cyc[8] <= obs_cyc[0]) begin
      n_bad++; $display("FAIL bp_read_after_fire: got pops=%0d want 9th pop after cycle %0d", pop_cyc.size(), obs_cyc[0]);
    end
  endtask

  task automatic test_period0();
    bit ok;
    clear_obs();
    spi_len = $urandom_range(4, 8);
    for (int i = 0; i < 3; i++) push_cmd(16'd0, 16'($urandom));
    wait_fires(3, 300, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL p0_fires: got %0d pulses want 3", obs_tx.size());
      return;
    end
    exp_cnt += 3;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs_tx[i] !== exp_tx[i]) begin n_bad++; $display("FAIL p0_tx%0d: got %h want %h", i, obs_tx[i], exp_tx[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (obs_cyc[i] - obs_cyc[i-1] != spi_len + 2) begin
        n_bad++; $display("FAIL p0_gap%0d: got %0d want %0d", i, obs_cyc[i] - obs_cyc[i-1], spi_len + 2);
      end
    end
    n_cmp++;
    if (overlap != 0) begin n_bad++; $display("FAIL p0_overlap: got %0d want 0", overlap); end
  endtask

  task automatic test_random();
    bit ok;
    int want;
    clear_obs();
    spi_len = $urandom_range(4, 8);
    for (int i = 0; i < 6; i++) push_cmd(16'($urandom_range(0, 30)), 16'($urandom));
    wait_fires(6, 1500, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL rnd_fires: got %0d pulses want 6", obs_tx.size());
      return;
    end
    exp_cnt += 6;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (obs_tx[i] !== exp_tx[i]) begin n_bad++; $display("FAIL rnd_tx%0d: got %h want %h", i, obs_tx[i], exp_tx[i]); end
    end
    for (int i = 1; i < 6; i++) begin
      want = (exp_per[i-1] > spi_len + 2) ? exp_per[i-1] : spi_len + 2;
      n_cmp++;
      if (obs_cyc[i] - obs_cyc[i-1] != want) begin
        n_bad++; $display("FAIL rnd_gap%0d: got %0d want %0d", i, obs_cyc[i] - obs_cyc[i-1], want);
      end
    end
    @(negedge clk);
    #1;
    n_cmp += 2;
    if (bus.cmd_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL rnd_cmd_cnt: got %0d want %0d", bus.cmd_cnt, exp_cnt); end
    if (overlap != 0 || overread != 0) begin n_bad++; $display("FAIL rnd_protocol: got overlap=%0d overread=%0d want 0/0", overlap, overread); end
  endtask

  task automatic test_gaps();
    bit ok;
    clear_obs();
    spi_len = 4;
    gap = 1'b1;
    push_cmd(16'hABCD, 16'h0004);
    wait_fires(1, 200, ok);
    gap = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL gap_fire: got %0d pulses want 1", obs_tx.size());
      return;
    end
    n_cmp += 2;
    if (obs_tx[0] !== 16'h0001) begin n_bad++; $display("FAIL gap_tx: got %h want 0001", obs_tx[0]); end
    if (rd_count != 4 || overread != 0) begin n_bad++; $display("FAIL gap_reads: got %0d/%0d want 4/0", rd_count, overread); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k = 0;
    clear_obs();
    hold = 1'b1;
    fifo_q.push_back(8'h12);
    fifo_q.push_back(8'h34);
    while (rd_count < 2 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_cmp++;
    if (rd_count < 2) begin n_bad++; $display("FAIL rmid_partial: got %0d reads want 2", rd_count); end
    resetn = 1'b0;
    #1;
    n_cmp += 6;
    if (bus.fifo_rd !== 1'b0) begin n_bad++; $display("FAIL rmid_fifo_rd: got %b want 0", bus.fifo_rd); end
    if (bus.spi_we !== 1'b0) begin n_bad++; $display("FAIL rmid_spi_we: got %b want 0", bus.spi_we); end
    if (bus.spi_tx !== 16'h0000) begin n_bad++; $display("FAIL rmid_spi_tx: got %h want 0000", bus.spi_tx); end
    if (bus.csn !== 1'b1) begin n_bad++; $display("FAIL rmid_csn: got %b want 1", bus.csn); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
    if (bus.cmd_cnt !== 16'h0000) begin n_bad++; $display("FAIL rmid_cmd_cnt: got %h want 0000", bus.cmd_cnt); end
    hold = 1'b0;
    repeat (2) @(negedge clk);
    resetn  = 1'b1;
    exp_cnt = 0;
    clear_obs();
    push_cmd(16'h0001, 16'hFFFC);
    wait_fires(1, 100, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL rmid_fire: got %0d pulses want 1", obs_tx.size());
      return;
    end
    @(negedge clk);
    #1;
    n_cmp += 2;
    if (obs_tx[0] !== 16'h3FFF) begin n_bad++; $display("FAIL rmid_tx: got %h want 3fff", obs_tx[0]); end
    if (bus.cmd_cnt !== 16'd1) begin n_bad++; $display("FAIL rmid_cmd_cnt_after: got %0d want 1", bus.cmd_cnt); end
  endtask

  initial begin
    resetn = 1'b0;
    test_reset();
    test_single();
    test_pacing();
    test_backpressure();
    test_period0();
    test_random();
    test_gaps();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
